// File: rtl/instr_fetch_ctrl.sv
// instr_fetch_ctrl: shares one instruction memory between the loader and PC-driven fetch, feeding words to the decoder over valid/ready.
// Define IFETCH_HALT_ZERO_EN to make an all-zero fetched word halt the sequencer after it is delivered.
module instr_fetch_ctrl #(
  parameter int DATA_W = 32,
  parameter int MEM_DEPTH = 64,
  parameter int RD_LAT = 1,
  parameter int RESET_PC = 0,
  localparam int AW = $clog2(MEM_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              halt_req,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [AW-1:0]     ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              br_valid,
  input  logic [AW-1:0]     br_target,
  output logic              mem_we,
  output logic [AW-1:0]     mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr_out,
  output logic [AW-1:0]     instr_pc,
  output logic              busy
);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, HOLD, HALTED} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] pc_q, pc_d, ipc_q, ipc_d;
  logic [1:0] lat_q, lat_d;
  logic valid_q, valid_d, halt_q, halt_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic ld_own, zero_stop;
  assign ld_own = state_q == IDLE || state_q == HALTED;
`ifdef IFETCH_HALT_ZERO_EN
  assign zero_stop = out_q == '0;
`else
  assign zero_stop = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    lat_d = lat_q;
    valid_d = valid_q;
    out_d = out_q;
    ipc_d = ipc_q;
    halt_d = halt_q;
    if (ld_own) begin
      halt_d = 1'b0;
      if (start && !ld_valid) begin
        pc_d = AW'(RESET_PC);
        state_d = ISSUE;
      end
    end else if (br_valid) begin
      pc_d = br_target;
      valid_d = 1'b0;
      state_d = ISSUE;
    end else begin
      halt_d = halt_q | halt_req;
      case (state_q)
        ISSUE: begin
          lat_d = 2'(RD_LAT - 1);
          state_d = WAIT;
        end
        WAIT: begin
          lat_d = lat_q - 1'b1;
          if (lat_q == '0) begin
            out_d = mem_rdata;
            ipc_d = pc_q;
            valid_d = 1'b1;
            state_d = HOLD;
          end
        end
        HOLD: if (instr_ready) begin
          pc_d = (pc_q == AW'(MEM_DEPTH - 1)) ? '0 : pc_q + 1'b1;
          valid_d = 1'b0;
          state_d = (halt_q || halt_req || zero_stop) ? HALTED : ISSUE;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      pc_q <= AW'(RESET_PC);
      lat_q <= '0;
      valid_q <= 1'b0;
      out_q <= '0;
      ipc_q <= '0;
      halt_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      lat_q <= lat_d;
      valid_q <= valid_d;
      out_q <= out_d;
      ipc_q <= ipc_d;
      halt_q <= halt_d;
    end
  end
  // Loader-facing outputs are gated by rst so a write in progress drops the moment reset asserts.
  assign ld_ready = rst && ld_own && ld_valid;
  assign mem_we = ld_ready;
  assign mem_addr = !rst ? '0 : ld_own ? ld_addr : pc_q;
  assign mem_wdata = (rst && ld_own) ? ld_data : '0;
  assign instr_valid = valid_q;
  assign instr_out = out_q;
  assign instr_pc = ipc_q;
  assign busy = !ld_own;
endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// tb_instr_fetch_ctrl: directed/random bench for instr_fetch_ctrl with a latency-accurate memory and a reference
// image of loaded words; expected fetch order follows pc+1 mod depth, redirects and halts.
module tb_instr_fetch_ctrl;
  localparam int DW = 32, DEPTH = 64, AW = 6, RD_LAT = 1;
  logic clk = 0, rst = 1, start = 0, halt_req = 0, ld_valid = 0, br_valid = 0, instr_ready = 0;
  logic [AW-1:0] ld_addr = '0, br_target = '0;
  logic [DW-1:0] ld_data = '0, mem_rdata;
  logic ld_ready, mem_we, instr_valid, busy;
  logic [AW-1:0] mem_addr, instr_pc;
  logic [DW-1:0] mem_wdata, instr_out;
  logic [DW-1:0] dev_mem [DEPTH];
  logic [DW-1:0] rd_pipe [RD_LAT];
  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] w;
  int n_chk = 0, n_fail = 0, cyc = 0, last_hs = -1, exp_pc = 0;

  instr_fetch_ctrl #(.DATA_W(DW), .MEM_DEPTH(DEPTH), .RD_LAT(RD_LAT), .RESET_PC(0)) dut (
    .clk(clk), .rst(rst), .start(start), .halt_req(halt_req),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
    .br_valid(br_valid), .br_target(br_target),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_out(instr_out),
    .instr_pc(instr_pc), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    if (mem_we) dev_mem[mem_addr] <= mem_wdata;
    rd_pipe[0] <= dev_mem[mem_addr];
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rdata = rd_pipe[RD_LAT-1];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    n_chk++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept n words with instr_ready high, checking order, content and spacing.
  task automatic expect_words(input int n);
    for (int k = 0; k < n; k++) begin
      int wt = 0;
      while (!instr_valid && wt < 20) begin
        tick();
        wt++;
      end
      chk("fetch_valid", instr_valid, 1);
      chk("fetch_pc", instr_pc, exp_pc);
      chk("fetch_word", instr_out, ref_mem[exp_pc]);
      if (last_hs >= 0) chk("fetch_period", cyc - last_hs, RD_LAT + 2);
      last_hs = cyc;
      exp_pc = (exp_pc + 1) % DEPTH;
      tick();
    end
  endtask

  initial begin
    ld_valid = 1; ld_addr = 6'd9; ld_data = 32'hdead_beef;
    #1 rst = 0;
    #2;
    chk("rst_mem_we", mem_we, 0);
    chk("rst_ld_ready", ld_ready, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_instr_valid", instr_valid, 0);
    chk("rst_instr_out", instr_out, 0);
    chk("rst_instr_pc", instr_pc, 0);
    chk("rst_busy", busy, 0);
    tick();
    rst = 1; ld_valid = 0;
    for (int a = 0; a < DEPTH; a++) begin
      w = (a == 20) ? '0 : ($urandom() | 32'h1);
      ref_mem[a] = w;
      ld_valid = 1; ld_addr = AW'(a); ld_data = w;
      #1;
      chk("ld_ready", ld_ready, 1);
      chk("ld_we", mem_we, 1);
      chk("ld_addr", mem_addr, a);
      chk("ld_wdata", mem_wdata, w);
      tick();
    end
    ld_valid = 0;
    chk("idle_busy", busy, 0);
    start = 1; instr_ready = 1;
    tick();
    start = 0;
    chk("run_busy", busy, 1);
    exp_pc = 0; last_hs = -1;
    expect_words(2);
    instr_ready = 0;
    for (int i = 0; i < 20 && !instr_valid; i++) tick();
    ld_valid = 1; ld_addr = 6'd5; ld_data = 32'h1234_5678;
    #1;
    chk("run_ld_ready", ld_ready, 0);
    chk("run_mem_we", mem_we, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid", instr_valid, 1);
      chk("bp_pc", instr_pc, 2);
      chk("bp_word", instr_out, ref_mem[2]);
      chk("bp_mem_addr", mem_addr, 2);
    end
    ld_valid = 0; instr_ready = 1;
    exp_pc = 2; last_hs = -1;
    expect_words(1);
    tick();
    br_valid = 1; br_target = 6'd10;
    tick();
    br_valid = 0;
    chk("br_flush", instr_valid, 0);
    exp_pc = 10; last_hs = -1;
    expect_words(2);
    br_valid = 1; br_target = 6'd62;
    tick();
    br_valid = 0;
    exp_pc = 62; last_hs = -1;
    expect_words(4);
    expect_words(2);
    tick();
    halt_req = 1;
    expect_words(1);
    chk("halt_busy", busy, 0);
    chk("halt_valid", instr_valid, 0);
    halt_req = 0;
    w = $urandom() | 32'h1;
    ref_mem[5] = w;
    ld_valid = 1; ld_addr = 6'd5; ld_data = w; start = 1;
    #1;
    chk("halt_ld_ready", ld_ready, 1);
    chk("halt_mem_we", mem_we, 1);
    tick();
    start = 0; ld_valid = 0;
    chk("start_dropped", busy, 0);
    br_valid = 1; br_target = 6'd30;
    tick();
    br_valid = 0;
    chk("br_halted_busy", busy, 0);
    chk("br_halted_valid", instr_valid, 0);
    start = 1;
    tick();
    start = 0;
    br_valid = 1; br_target = 6'd20;
    tick();
    br_valid = 0;
    exp_pc = 20; last_hs = -1;
    expect_words(1);
`ifdef IFETCH_HALT_ZERO_EN
    chk("zero_halt_busy", busy, 0);
    start = 1;
    tick();
    start = 0;
`else
    expect_words(1);
    chk("zero_cont_busy", busy, 1);
`endif
    tick();
    ld_valid = 1; ld_addr = 6'd7; ld_data = 32'hffff_ffff;
    #2 rst = 0;
    #1;
    chk("arst_mem_we", mem_we, 0);
    chk("arst_ld_ready", ld_ready, 0);
    chk("arst_mem_addr", mem_addr, 0);
    chk("arst_mem_wdata", mem_wdata, 0);
    chk("arst_busy", busy, 0);
    chk("arst_valid", instr_valid, 0);
    chk("arst_out", instr_out, 0);
    chk("arst_pc", instr_pc, 0);
    tick();
    ld_valid = 0; rst = 1;
    #1;
    chk("post_rst_busy", busy, 0);
    start = 1;
    tick();
    start = 0;
    exp_pc = 0; last_hs = -1;
    expect_words(6);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
